// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_8by4_seq_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int VW = DIV_VW
) (
    input  logic [VW:0]   pr_i,
    input  logic          bit_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   pr_o,
    output logic          q_o
);

    logic [VW+1:0] trial_s;
    logic [VW+1:0] dext_s;

    // Trial subtraction; the top trial bit only matters for the compare and is dropped afterwards.
    always_comb begin
        trial_s = {pr_i, bit_i};
        dext_s  = {2'b00, d_i};
        if (trial_s >= dext_s) begin
            pr_o = (VW+1)'(trial_s - dext_s);
            q_o  = 1'b1;
        end else begin
            pr_o = (VW+1)'(trial_s);
            q_o  = 1'b0;
        end
    end

endmodule

// File: rtl/div_8by4_seq.sv
// Sequential DW-by-VW unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_CHK_EN: short-circuit b=0 straight to DONE with dz=1.
module div_8by4_seq
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    div_state_e    state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [VW-1:0] b_q, b_d;
    logic [VW:0]   pr_q, pr_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          dz_q, dz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [VW:0]   step_pr_s;
    logic          step_q_s;

    div_step #(.VW(VW)) u_step (
        .pr_i  (pr_q),
        .bit_i (a_q[DW-1]),
        .d_i   (b_q),
        .pr_o  (step_pr_s),
        .q_o   (step_q_s)
    );

    // State and datapath registers; reset clears everything visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath logic; the dividend register shifts so its MSB is always the next bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        pr_d    = pr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    pr_d  = '0;
                    cnt_d = '0;
                    dz_d  = 1'b0;
`ifdef DIV_ZERO_CHK_EN
                    if (b == '0) begin
                        state_d = ST_DONE;
                        q_d     = '1;
                        r_d     = a[VW-1:0];
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = {a_q[DW-2:0], 1'b0};
                pr_d  = step_pr_s;
                q_d   = {q_q[DW-2:0], step_q_s};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = ST_DONE;
                    r_d     = step_pr_s[VW-1:0];
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div_8by4_seq.sv
// Scoreboard bench for div_8by4_seq: randomized and exhaustive divisions against an arithmetic model.
module tb_div_8by4_seq;

    localparam int DW = 8;
    localparam int VW = 4;
`ifdef DIV_ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic          busy, done, dz;
    logic [DW-1:0] q;
    logic [VW-1:0] r;

    res_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   issued    = 0;
    int   aborted   = 0;
    int   done_seen = 0;

    always #5 clk = ~clk;

    div_8by4_seq #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    function automatic res_t model(input int unsigned av, input int unsigned bv);
        res_t m;
        if (bv == 0) begin
            m.q  = '1;
            m.r  = VW'(av % (1 << VW));
            m.dz = ZCHK;
        end else begin
            m.q  = DW'(av / bv);
            m.r  = VW'(av % bv);
            m.dz = 1'b0;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        res_t e;
        if (done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done got q=%0d r=%0d expected no done", q, r);
            end else begin
                e = exp_q.pop_front();
                check("q", 32'(q), 32'(e.q));
                check("r", 32'(r), 32'(e.r));
                check("dz", 32'(dz), 32'(e.dz));
            end
        end
    end

    task automatic start_op(input int unsigned av, input int unsigned bv);
        a     = DW'(av);
        b     = VW'(bv);
        start = 1'b1;
        exp_q.push_back(model(av, bv));
        issued++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done from period 1 after the start edge; optionally re-pulses start with new operands.
    task automatic wait_done(input int inj_at, input res_t e, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            if (k == inj_at) begin
                start = 1'b1;
                a     = ~a;
                b     = b ^ 4'h5;
            end else if (k == inj_at + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = k;
            end else begin
                bcnt += int'(busy);
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got no done expected within 30 cycles");
        end else begin
            @(negedge clk);
            check("hold_q", 32'(q), 32'(e.q));
            check("hold_r", 32'(r), 32'(e.r));
            check("done_pulse_width", 32'(done), 32'd0);
        end
    endtask

    task automatic run_div(input int unsigned av, input int unsigned bv, input int inj_at);
        res_t e;
        int   lat, bcnt;
        e = model(av, bv);
        start_op(av, bv);
        wait_done(inj_at, e, lat, bcnt);
        if (!(ZCHK && bv == 0)) begin
            check("latency", 32'(lat), 32'(DW + 1));
            check("busy_cycles", 32'(bcnt), 32'(DW));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);

        // reset wins over a simultaneous start
        start = 1'b1;
        a     = 8'd200;
        b     = 4'd7;
        @(negedge clk);
        check("rst_prio_busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run_div(200, 7, 0);
        run_div(255, 1, 0);
        run_div(5, 15, 0);
        run_div(77, 0, 0);

        // start re-pulsed during RUN must be ignored
        run_div(100, 9, 3);
        repeat (12) @(negedge clk);

        // reset in the middle of RUN abandons the division
        start_op(150, 11);
        void'(exp_q.pop_back());
        aborted++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_r", 32'(r), 32'd0);
        repeat (12) @(negedge clk);
        run_div(150, 11, 0);

        for (int i = 0; i < 300; i++) begin
            run_div($urandom_range(255, 0), $urandom_range(15, 0), 0);
        end

        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 1; bi < 16; bi++) begin
                run_div(ai, bi, 0);
            end
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(issued - aborted));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
